ladybird_core_mc: RTL and testbench

- Parametrised multi-cycle RV32I/RV32E integer core. Next generation of the single-issue ladybird core.
- Adds a configurable reset vector and register-file depth.
- Adds full byte/halfword/word load-store with lane steering and sign extension.
- Adds trap-to-halt for illegal, misaligned and system instructions, plus retire/trace outputs.
- Sits between the instruction and data memory ports. Reuses ladybird_alu for arithmetic.

---
 rtl/ladybird_core_mc.sv | 367 ++++++++++++++++++++++++++++++++++++
 tb/tb_ladybird_core_mc.sv | 328 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ladybird_core_mc.sv
// ladybird_core_mc: multi-cycle RV32I/RV32E core with trap-to-halt.
// ladybird_alu provides the shared integer datapath.
module ladybird_alu (
   input  logic [3:0]  op,
   input  logic [31:0] a,
   input  logic [31:0] b,
   output logic [31:0] y
);
   logic [4:0] sh;
   assign sh = b[4:0];

   // op = {alt, funct3}; alt selects SUB/SRA
   always_comb begin
      y = '0;
      unique case (op)
         4'b0000:          y = a + b;
         4'b1000:          y = a - b;
         4'b0001, 4'b1001: y = a << sh;
         4'b0010, 4'b1010: y = {31'b0, $signed(a) < $signed(b)};
         4'b0011, 4'b1011: y = {31'b0, a < b};
         4'b0100, 4'b1100: y = a ^ b;
         4'b0101:          y = a >> sh;
         4'b1101:          y = $signed(a) >>> sh;
         4'b0110, 4'b1110: y = a | b;
         default:          y = a & b;
      endcase
   end
endmodule

module ladybird_core_mc #(
   parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
   parameter int          NUM_GPR      = 32,
   parameter bit          SIMULATION   = 1'b0
) (
   input  logic        clk,
   input  logic        anrst,
   output logic        i_req,
   output logic [31:0] i_addr,
   input  logic        i_gnt,
   input  logic        i_rvalid,
   input  logic [31:0] i_rdata,
   output logic        d_req,
   output logic [31:0] d_addr,
   output logic        d_we,
   output logic [3:0]  d_wstrb,
   output logic [31:0] d_wdata,
   input  logic        d_gnt,
   input  logic        d_rvalid,
   input  logic [31:0] d_rdata,
   output logic        retire,
   output logic [31:0] retire_pc,
   output logic        halted,
   output logic [1:0]  trap_cause
);
   localparam int RW = $clog2(NUM_GPR);

   localparam logic [6:0] OP_LUI    = 7'b0110111;
   localparam logic [6:0] OP_AUIPC  = 7'b0010111;
   localparam logic [6:0] OP_JAL    = 7'b1101111;
   localparam logic [6:0] OP_JALR   = 7'b1100111;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_IMM    = 7'b0010011;
   localparam logic [6:0] OP_OP     = 7'b0110011;
   localparam logic [6:0] OP_FENCE  = 7'b0001111;
   localparam logic [6:0] OP_SYSTEM = 7'b1110011;

   typedef enum logic [2:0] {
      S_FETCH, S_WAIT_I, S_DECODE, S_EXEC,
      S_MEM_REQ, S_MEM_WAIT, S_COMMIT, S_HALT
   } state_t;

   state_t state, state_nx;

   logic [31:0] pc, inst, rs1_v, rs2_v, res, npc, ld_v;
   logic [1:0]  cause, trap_nx;
   logic [31:0] rf [NUM_GPR];
   logic        fetch_req;

   logic [6:0] opc, f7;
   logic [4:0] rd, rs1, rs2;
   logic [2:0] f3;

   assign opc = inst[6:0];
   assign rd  = inst[11:7];
   assign f3  = inst[14:12];
   assign rs1 = inst[19:15];
   assign rs2 = inst[24:20];
   assign f7  = inst[31:25];

   logic is_lui, is_auipc, is_jal, is_jalr, is_br;
   logic is_load, is_store, is_opimm, is_op;
   logic is_fence, is_sys;

   assign is_lui   = opc == OP_LUI;
   assign is_auipc = opc == OP_AUIPC;
   assign is_jal   = opc == OP_JAL;
   assign is_jalr  = opc == OP_JALR;
   assign is_br    = opc == OP_BRANCH;
   assign is_load  = opc == OP_LOAD;
   assign is_store = opc == OP_STORE;
   assign is_opimm = opc == OP_IMM;
   assign is_op    = opc == OP_OP;
   assign is_fence = opc == OP_FENCE;
   assign is_sys   = opc == OP_SYSTEM;

   logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;

   assign imm_i = {{20{inst[31]}}, inst[31:20]};
   assign imm_s = {{20{inst[31]}}, inst[31:25], inst[11:7]};
   assign imm_b = {{19{inst[31]}}, inst[31], inst[7],
                   inst[30:25], inst[11:8], 1'b0};
   assign imm_u = {inst[31:12], 12'b0};
   assign imm_j = {{11{inst[31]}}, inst[31], inst[19:12],
                   inst[20], inst[30:21], 1'b0};

   logic use_rd, use_rs1, use_rs2;
   logic known, bad_f, bad_reg, illegal;

   assign use_rd  = is_lui | is_auipc | is_jal | is_jalr |
                    is_load | is_opimm | is_op;
   assign use_rs1 = is_jalr | is_br | is_load | is_store |
                    is_opimm | is_op;
   assign use_rs2 = is_br | is_store | is_op;

   assign known = is_lui | is_auipc | is_jal | is_jalr | is_br |
                  is_load | is_store | is_opimm | is_op |
                  is_fence | is_sys;

   assign bad_f =
      (is_load && (f3 == 3'b011 || f3[2:1] == 2'b11)) ||
      (is_store && f3 > 3'b010) ||
      (is_op && !(f7 == 7'b0000000 ||
                  (f7 == 7'b0100000 &&
                   (f3 == 3'b000 || f3 == 3'b101))));

   // RV32E only has x0..x15; bit 4 of a used index is out of range
   assign bad_reg = (NUM_GPR == 16) &&
                    ((use_rd && rd[4]) || (use_rs1 && rs1[4]) ||
                     (use_rs2 && rs2[4]));

   assign illegal = !known || bad_f || bad_reg;

   logic [31:0] alu_a, alu_b, alu_y;
   logic [3:0]  alu_op;

   always_comb begin
      alu_a  = rs1_v;
      alu_b  = imm_i;
      alu_op = 4'b0000;
      unique case (1'b1)
         is_op: begin
            alu_b  = rs2_v;
            alu_op = {f7[5], f3};
         end
         is_opimm: alu_op = {f3 == 3'b101 && f7[5], f3};
         is_store: alu_b = imm_s;
         is_lui: begin
            alu_a = '0;
            alu_b = imm_u;
         end
         is_auipc: begin
            alu_a = pc;
            alu_b = imm_u;
         end
         is_jal, is_jalr: begin
            alu_a = pc;
            alu_b = 32'd4;
         end
         default: ;
      endcase
   end

   ladybird_alu u_alu (
      .op (alu_op),
      .a  (alu_a),
      .b  (alu_b),
      .y  (alu_y)
   );

   logic        take, is_cf;
   logic [31:0] npc_c;

   always_comb begin
      take = 1'b0;
      case (f3)
         3'b000:  take = rs1_v == rs2_v;
         3'b001:  take = rs1_v != rs2_v;
         3'b100:  take = $signed(rs1_v) < $signed(rs2_v);
         3'b101:  take = $signed(rs1_v) >= $signed(rs2_v);
         3'b110:  take = rs1_v < rs2_v;
         3'b111:  take = rs1_v >= rs2_v;
         default: take = 1'b0;
      endcase
   end

   always_comb begin
      npc_c = pc + 32'd4;
      if (is_jal)
         npc_c = pc + imm_j;
      else if (is_jalr)
         npc_c = (rs1_v + imm_i) & ~32'd1;
      else if (is_br && take)
         npc_c = pc + imm_b;
   end

   assign is_cf = is_jal | is_jalr | (is_br & take);

   logic        mis;
   logic [3:0]  wstrb;
   logic [31:0] wdata, ld_sh, ld_ext;

   assign mis = (f3[1:0] == 2'b01 && res[0]) ||
                (f3[1:0] == 2'b10 && res[1:0] != 2'b00);

   always_comb begin
      wstrb = 4'b1111;
      wdata = rs2_v;
      case (f3[1:0])
         2'b00: begin
            wstrb = 4'b0001 << res[1:0];
            wdata = {4{rs2_v[7:0]}};
         end
         2'b01: begin
            wstrb = 4'b0011 << res[1:0];
            wdata = {2{rs2_v[15:0]}};
         end
         default: ;
      endcase
   end

   assign ld_sh = d_rdata >> {res[1:0], 3'b000};

   always_comb begin
      ld_ext = ld_sh;
      case (f3)
         3'b000:  ld_ext = {{24{ld_sh[7]}}, ld_sh[7:0]};
         3'b001:  ld_ext = {{16{ld_sh[15]}}, ld_sh[15:0]};
         3'b100:  ld_ext = {24'b0, ld_sh[7:0]};
         3'b101:  ld_ext = {16'b0, ld_sh[15:0]};
         default: ld_ext = ld_sh;
      endcase
   end

   always_ff @(posedge clk or negedge anrst) begin
      if (!anrst)
         state <= S_FETCH;
      else
         state <= state_nx;
   end

   always_comb begin
      state_nx  = state;
      fetch_req = 1'b0;
      d_req     = 1'b0;
      retire    = 1'b0;
      trap_nx   = 2'd0;
      unique case (state)
         S_FETCH: begin
            fetch_req = 1'b1;
            if (i_gnt)
               state_nx = S_WAIT_I;
         end
         S_WAIT_I:
            if (i_rvalid)
               state_nx = S_DECODE;
         S_DECODE:
            if (illegal) begin
               state_nx = S_HALT;
               trap_nx  = 2'd1;
            end else if (is_sys) begin
               state_nx = S_HALT;
               trap_nx  = 2'd3;
            end else begin
               state_nx = S_EXEC;
            end
         S_EXEC:
            if (is_cf && npc_c[1]) begin
               state_nx = S_HALT;
               trap_nx  = 2'd2;
            end else if (is_load || is_store) begin
               state_nx = S_MEM_REQ;
            end else begin
               state_nx = S_COMMIT;
            end
         S_MEM_REQ:
            if (mis) begin
               state_nx = S_HALT;
               trap_nx  = 2'd2;
            end else begin
               d_req = 1'b1;
               if (d_gnt)
                  state_nx = is_store ? S_COMMIT : S_MEM_WAIT;
            end
         S_MEM_WAIT:
            if (d_rvalid)
               state_nx = S_COMMIT;
         S_COMMIT: begin
            retire   = 1'b1;
            state_nx = S_FETCH;
         end
         S_HALT: ;
         default: state_nx = S_HALT;
      endcase
   end

   always_ff @(posedge clk or negedge anrst) begin
      if (!anrst) begin
         pc    <= RESET_VECTOR;
         inst  <= '0;
         rs1_v <= '0;
         rs2_v <= '0;
         res   <= '0;
         npc   <= '0;
         ld_v  <= '0;
         cause <= 2'd0;
      end else begin
         if (state == S_WAIT_I && i_rvalid)
            inst <= i_rdata;
         if (state == S_DECODE) begin
            rs1_v <= rf[rs1[RW-1:0]];
            rs2_v <= rf[rs2[RW-1:0]];
         end
         if (state == S_EXEC) begin
            res <= alu_y;
            npc <= npc_c;
         end
         if (state == S_MEM_WAIT && d_rvalid)
            ld_v <= ld_ext;
         if (state == S_COMMIT)
            pc <= npc;
         if (state != S_HALT && state_nx == S_HALT)
            cause <= trap_nx;
      end
   end

   // x0 is never written, so it reads back as zero
   always_ff @(posedge clk or negedge anrst) begin
      if (!anrst) begin
         for (int i = 0; i < NUM_GPR; i++)
            rf[i] <= '0;
      end else if (state == S_COMMIT && use_rd && rd != 5'd0) begin
         rf[rd[RW-1:0]] <= is_load ? ld_v : res;
      end
   end

   assign i_req      = fetch_req & anrst;
   assign i_addr     = pc;
   assign d_addr     = d_req ? {res[31:2], 2'b00} : '0;
   assign d_we       = d_req & is_store;
   assign d_wstrb    = d_we ? wstrb : 4'b0000;
   assign d_wdata    = d_we ? wdata : '0;
   assign retire_pc  = pc;
   assign halted     = state == S_HALT;
   assign trap_cause = cause;

   if (SIMULATION) begin : g_sim
      always @(posedge clk) begin
         if (anrst) begin
            assert (NUM_GPR == 32 || NUM_GPR == 16);
            assert (!(i_req && d_req));
            assert (!(halted && (i_req || d_req)));
         end
      end
   end
endmodule

// File: tb/tb_ladybird_core_mc.sv
// Directed bench for ladybird_core_mc: bus models with scoreboards
// for retired pcs and data-bus transactions.
module tb_ladybird_core_mc;
   logic        clk, anrst;
   logic        i_req, i_gnt, i_rvalid;
   logic [31:0] i_addr, i_rdata;
   logic        d_req, d_we, d_gnt, d_rvalid;
   logic [31:0] d_addr, d_wdata, d_rdata;
   logic [3:0]  d_wstrb;
   logic        retire, halted;
   logic [31:0] retire_pc;
   logic [1:0]  trap_cause;

   logic        i_req16, i_gnt16, i_rvalid16;
   logic [31:0] i_addr16, i_rdata16;
   logic        d_req16, d_we16, d_gnt16, d_rvalid16;
   logic [31:0] d_addr16, d_wdata16, d_rdata16;
   logic [3:0]  d_wstrb16;
   logic        retire16, halted16;
   logic [31:0] retire_pc16;
   logic [1:0]  trap_cause16;

   ladybird_core_mc #(
      .RESET_VECTOR (32'h100), .NUM_GPR (32), .SIMULATION (1'b1)
   ) dut (
      .clk (clk), .anrst (anrst),
      .i_req (i_req), .i_addr (i_addr), .i_gnt (i_gnt),
      .i_rvalid (i_rvalid), .i_rdata (i_rdata),
      .d_req (d_req), .d_addr (d_addr), .d_we (d_we),
      .d_wstrb (d_wstrb), .d_wdata (d_wdata), .d_gnt (d_gnt),
      .d_rvalid (d_rvalid), .d_rdata (d_rdata),
      .retire (retire), .retire_pc (retire_pc),
      .halted (halted), .trap_cause (trap_cause)
   );

   ladybird_core_mc #(
      .RESET_VECTOR (32'h100), .NUM_GPR (16), .SIMULATION (1'b1)
   ) dut16 (
      .clk (clk), .anrst (anrst),
      .i_req (i_req16), .i_addr (i_addr16), .i_gnt (i_gnt16),
      .i_rvalid (i_rvalid16), .i_rdata (i_rdata16),
      .d_req (d_req16), .d_addr (d_addr16), .d_we (d_we16),
      .d_wstrb (d_wstrb16), .d_wdata (d_wdata16), .d_gnt (d_gnt16),
      .d_rvalid (d_rvalid16), .d_rdata (d_rdata16),
      .retire (retire16), .retire_pc (retire_pc16),
      .halted (halted16), .trap_cause (trap_cause16)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic        we;
      logic [31:0] addr;
      logic [3:0]  strb;
      logic [31:0] data;
   } dexp_t;

   logic [31:0] imem [256];
   logic [31:0] pc_q [$];
   dexp_t       d_q [$];
   int          rt_t [$];

   int n_vec, n_fail, tcnt, t0;
   int gnt_dly, d_dly, iw, ic, dc, n_ret16, n_dreq16;
   logic ip, dp, ip16, dp16;
   logic [31:0] ia, ia16, ihold, ld_word;

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] enc_i(input int imm, input int rs1,
      input int f3, input int rd, input logic [6:0] op);
      logic [31:0] v;
      v = imm;
      return {v[11:0], 5'(rs1), 3'(f3), 5'(rd), op};
   endfunction

   function automatic logic [31:0] enc_s(input int imm, input int rs2,
      input int rs1, input int f3);
      logic [31:0] v;
      v = imm;
      return {v[11:5], 5'(rs2), 5'(rs1), 3'(f3), v[4:0], 7'h23};
   endfunction

   function automatic logic [31:0] enc_r(input int f7, input int rs2,
      input int rs1, input int f3, input int rd);
      return {7'(f7), 5'(rs2), 5'(rs1), 3'(f3), 5'(rd), 7'h33};
   endfunction

   function automatic logic [31:0] enc_b(input int imm, input int rs2,
      input int rs1, input int f3);
      logic [31:0] v;
      v = imm;
      return {v[12], v[10:5], 5'(rs2), 5'(rs1), 3'(f3),
              v[4:1], v[11], 7'h63};
   endfunction

   function automatic logic [31:0] enc_j(input int imm, input int rd);
      logic [31:0] v;
      v = imm;
      return {v[20], v[10:1], v[11], v[19:12], 5'(rd), 7'h6f};
   endfunction

   task automatic put(input logic [31:0] addr, input logic [31:0] w);
      imem[addr[9:2]] = w;
   endtask

   task automatic exp_st(input logic [31:0] a, input logic [3:0] s,
                         input logic [31:0] d);
      dexp_t e;
      e.we = 1'b1; e.addr = a; e.strb = s; e.data = d;
      d_q.push_back(e);
   endtask

   task automatic exp_ld(input logic [31:0] a);
      dexp_t e;
      e.we = 1'b0; e.addr = a; e.strb = 4'b0; e.data = '0;
      d_q.push_back(e);
   endtask

   // One clock of both bus models plus scoreboard checks
   task automatic tick();
      dexp_t de;
      @(negedge clk);
      tcnt++;
      i_gnt = 1'b0;
      i_rvalid = 1'b0;
      if (ip) begin
         if (ic == 0) begin
            i_rvalid = 1'b1;
            i_rdata = imem[ia[9:2]];
            ip = 1'b0;
         end else ic--;
      end
      if (i_req) begin
         if (iw == 0) ihold = i_addr;
         else chk("i_addr_hold", i_addr, ihold);
         if (iw >= gnt_dly) begin
            i_gnt = 1'b1; ia = i_addr; ip = 1'b1; ic = 0; iw = 0;
         end else iw++;
      end
      d_gnt = 1'b0;
      d_rvalid = 1'b0;
      if (dp) begin
         if (dc == 0) begin
            d_rvalid = 1'b1;
            d_rdata = ld_word;
            dp = 1'b0;
         end else dc--;
      end
      if (d_req) begin
         d_gnt = 1'b1;
         if (d_q.size() == 0) begin
            chk("unexp_dreq", {31'b0, d_req}, 32'd0);
         end else begin
            de = d_q.pop_front();
            chk("d_we", {31'b0, d_we}, {31'b0, de.we});
            chk("d_addr", d_addr, de.addr);
            if (de.we) begin
               chk("d_wstrb", {28'b0, d_wstrb}, {28'b0, de.strb});
               chk("d_wdata", d_wdata, de.data);
            end
         end
         if (!d_we) begin
            dp = 1'b1;
            dc = d_dly;
         end
      end
      if (retire) begin
         rt_t.push_back(tcnt);
         if (pc_q.size() == 0)
            chk("unexp_retire", {31'b0, retire}, 32'd0);
         else
            chk("retire_pc", retire_pc, pc_q.pop_front());
      end
      i_rvalid16 = ip16;
      if (ip16) i_rdata16 = imem[ia16[9:2]];
      ip16 = i_req16;
      ia16 = i_addr16;
      i_gnt16 = i_req16;
      d_rvalid16 = dp16;
      dp16 = d_req16 && !d_we16;
      d_gnt16 = d_req16;
      if (d_req16) n_dreq16++;
      if (retire16) n_ret16++;
   endtask

   task automatic do_reset();
      anrst = 1'b0;
      ip = 0; dp = 0; ip16 = 0; dp16 = 0; iw = 0;
      i_gnt = 0; i_rvalid = 0; d_gnt = 0; d_rvalid = 0;
      i_gnt16 = 0; i_rvalid16 = 0; d_gnt16 = 0; d_rvalid16 = 0;
      n_ret16 = 0; n_dreq16 = 0;
      rt_t.delete();
      #1;
      chk("rst_i_req", {31'b0, i_req}, 32'd0);
      chk("rst_d_req", {31'b0, d_req}, 32'd0);
      chk("rst_retire", {31'b0, retire}, 32'd0);
      chk("rst_halted", {31'b0, halted}, 32'd0);
      chk("rst_cause", {30'b0, trap_cause}, 32'd0);
      chk("rst_halted16", {31'b0, halted16}, 32'd0);
      repeat (2) @(negedge clk);
      anrst = 1'b1;
      #1;
      chk("post_rst_i_req", {31'b0, i_req}, 32'd1);
      chk("post_rst_i_addr", i_addr, 32'h100);
      chk("post_rst_halted", {31'b0, halted}, 32'd0);
      t0 = tcnt + 1;
   endtask

   task automatic run_halt(input int budget);
      int n;
      n = 0;
      while (!(halted && halted16) && n < budget) begin
         tick();
         n++;
      end
      repeat (5) tick();
      chk("halted", {31'b0, halted}, 32'd1);
      chk("halt_i_req", {31'b0, i_req}, 32'd0);
      chk("pc_q_empty", pc_q.size(), 32'd0);
      chk("d_q_empty", d_q.size(), 32'd0);
   endtask

   task automatic clear_imem();
      for (int i = 0; i < 256; i++) imem[i] = 32'h0;
   endtask

   initial begin
      n_vec = 0; n_fail = 0; tcnt = 0;
      anrst = 1'b1;
      i_rdata = '0; d_rdata = '0; i_rdata16 = '0; d_rdata16 = '0;
      i_gnt = 0; i_rvalid = 0; d_gnt = 0; d_rvalid = 0;
      i_gnt16 = 0; i_rvalid16 = 0; d_gnt16 = 0; d_rvalid16 = 0;
      #2;

      // Lane steering, branches and jumps under a slow bus
      clear_imem();
      put(32'h100, enc_i(-1, 0, 0, 1, 7'h13));
      put(32'h104, enc_s(3, 1, 0, 0));
      put(32'h108, enc_i(2, 0, 1, 3, 7'h03));
      put(32'h10C, enc_s(0, 3, 0, 2));
      put(32'h110, enc_i(2, 0, 5, 4, 7'h03));
      put(32'h114, enc_s(4, 4, 0, 2));
      put(32'h118, enc_i(1, 0, 0, 5, 7'h03));
      put(32'h11C, enc_s(8, 5, 0, 2));
      put(32'h120, enc_s(2, 3, 0, 1));
      put(32'h124, enc_b(8, 0, 0, 0));
      put(32'h128, enc_i(1, 0, 0, 6, 7'h13));
      put(32'h12C, enc_j(8, 7));
      put(32'h130, enc_i(1, 0, 0, 6, 7'h13));
      put(32'h134, enc_s(12, 7, 0, 2));
      put(32'h138, enc_b(8, 0, 0, 1));
      put(32'h13C, enc_r(0, 1, 1, 0, 8));
      put(32'h140, enc_s(16, 8, 0, 2));
      put(32'h144, 32'h0000_0073);
      foreach (pc_q[i]) pc_q.delete();
      pc_q = '{32'h100, 32'h104, 32'h108, 32'h10C, 32'h110,
               32'h114, 32'h118, 32'h11C, 32'h120, 32'h124,
               32'h12C, 32'h134, 32'h138, 32'h13C, 32'h140};
      exp_st(32'h0, 4'b1000, 32'hFFFF_FFFF);
      exp_ld(32'h0);
      exp_st(32'h0, 4'b1111, 32'hFFFF_8000);
      exp_ld(32'h0);
      exp_st(32'h4, 4'b1111, 32'h0000_8000);
      exp_ld(32'h0);
      exp_st(32'h8, 4'b1111, 32'h0000_007F);
      exp_st(32'h0, 4'b1100, 32'h8000_8000);
      exp_st(32'hC, 4'b1111, 32'h0000_0130);
      exp_st(32'h10, 4'b1111, 32'hFFFF_FFFE);
      gnt_dly = 3; d_dly = 5; ld_word = 32'h8000_7F00;
      do_reset();
      run_halt(3000);
      chk("ecall_cause", {30'b0, trap_cause}, 32'd3);
      chk("ecall_pc", retire_pc, 32'h144);

      // Zero-wait latency and misaligned load
      clear_imem();
      put(32'h100, enc_i(4, 0, 0, 1, 7'h13));
      put(32'h104, enc_i(0, 1, 2, 2, 7'h03));
      put(32'h108, enc_s(8, 2, 0, 2));
      put(32'h10C, enc_i(2, 0, 2, 2, 7'h03));
      pc_q = '{32'h100, 32'h104, 32'h108};
      exp_ld(32'h4);
      exp_st(32'h8, 4'b1111, 32'h1234_5678);
      gnt_dly = 0; d_dly = 0; ld_word = 32'h1234_5678;
      do_reset();
      run_halt(1000);
      chk("mis_cause", {30'b0, trap_cause}, 32'd2);
      chk("mis_pc", retire_pc, 32'h10C);
      chk("n_retire_b", rt_t.size(), 32'd3);
      if (rt_t.size() == 3) begin
         chk("lat_alu", rt_t[0] - t0, 32'd4);
         chk("lat_load", rt_t[1] - rt_t[0], 32'd7);
         chk("lat_store", rt_t[2] - rt_t[1], 32'd6);
      end

      // RV32E register range and misaligned jump target
      clear_imem();
      put(32'h100, enc_i(5, 0, 0, 1, 7'h13));
      put(32'h104, enc_i(7, 0, 0, 2, 7'h13));
      put(32'h108, enc_r(0, 2, 1, 0, 17));
      put(32'h10C, enc_s(0, 17, 0, 2));
      put(32'h110, enc_j(2, 0));
      pc_q = '{32'h100, 32'h104, 32'h108, 32'h10C};
      exp_st(32'h0, 4'b1111, 32'd12);
      do_reset();
      run_halt(1000);
      chk("jmp_cause", {30'b0, trap_cause}, 32'd2);
      chk("jmp_pc", retire_pc, 32'h110);
      chk("e_halted", {31'b0, halted16}, 32'd1);
      chk("e_cause", {30'b0, trap_cause16}, 32'd1);
      chk("e_pc", retire_pc16, 32'h108);
      chk("e_retires", n_ret16, 32'd2);
      chk("e_dreq", n_dreq16, 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==",
               n_vec, n_fail);
      $finish;
   end
endmodule
